// File: rtl/ram_sdp_bytewr.sv
// ram_sdp_bytewr: simple dual-port RAM (one write port, one read port) with
// per-byte write enables and a self-clearing sweep.
//
// After reset, or on a clr request, the block walks every word and writes
// zero, one word per cycle. While the sweep runs, busy is high and every
// read or write request is rejected. Each rejected request raises dropped
// for one cycle.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset; restarts the clear sweep
//   clr       request a clear sweep (honoured only when not busy)
//   wrEn      write request
//   wrAddr    write address (taken modulo ADDRESS_DEPTH)
//   wrData    write data
//   wrByteEn  per-byte write enable, bit k covers wrData[8k+7:8k]
//   rdEn      read request
//   rdAddr    read address (taken modulo ADDRESS_DEPTH)
//   rdData    registered read data, held when no read is accepted
//   rdValid   rdData was updated by an accepted read at the last edge
//   busy      clear sweep in progress
//   dropped   a request was rejected at the last edge because busy
module ram_sdp_bytewr #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_SIZE  = 10,
  parameter int ADDRESS_DEPTH = 2**ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    wrEn,
  input  logic [ADDRESS_SIZE-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0]   wrData,
  input  logic [DATA_WIDTH/8-1:0] wrByteEn,
  input  logic                    rdEn,
  input  logic [ADDRESS_SIZE-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0]   rdData,
  output logic                    rdValid,
  output logic                    busy,
  output logic                    dropped
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(ADDRESS_DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] clrAddr;
  logic [ADDRESS_SIZE-1:0] wrIdx;
  logic [ADDRESS_SIZE-1:0] rdIdx;
  logic [DATA_WIDTH-1:0]   mem [ADDRESS_DEPTH];
  logic [DATA_WIDTH-1:0]   rdWord;
  logic [DATA_WIDTH-1:0]   rdMerged;
  logic                    wrAcc;
  logic                    rdAcc;
  logic                    sameAddr;

  // Folds any address into range, so a non-power-of-two depth can never
  // index past the array.
  function automatic logic [ADDRESS_SIZE-1:0] wrapAddr(input logic [ADDRESS_SIZE-1:0] a);
    return ADDRESS_SIZE'(32'(a) % 32'(ADDRESS_DEPTH));
  endfunction

  assign busy     = (state == CLEAR);
  assign wrAcc    = wrEn & ~busy;
  assign rdAcc    = rdEn & ~busy;
  assign wrIdx    = wrapAddr(wrAddr);
  assign rdIdx    = wrapAddr(rdAddr);
  assign sameAddr = (wrIdx == rdIdx);
  assign rdWord   = mem[rdIdx];

  // Write-first bypass: on a same-address collision, each enabled byte comes
  // from the incoming write and each disabled byte from the stored word.
  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    assign rdMerged[8*g +: 8] = (wrAcc && wrByteEn[g] && sameAddr) ? wrData[8*g +: 8]
                                                                   : rdWord[8*g +: 8];
  end

  // Storage has no reset. Zeroing happens only through the sweep, one word
  // per cycle. The sweep and user writes cannot overlap, because a user
  // write needs busy low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem[clrAddr] <= '0;
      end else if (wrAcc) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wrByteEn[b]) mem[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clrAddr <= '0;
      rdData  <= '0;
      rdValid <= 1'b0;
      dropped <= 1'b0;
    end else begin
      rdValid <= 1'b0;
      dropped <= 1'b0;
      case (state)
        CLEAR: begin
          // clr is ignored here, so a running sweep never restarts.
          dropped <= rdEn | wrEn;
          if (clrAddr == LAST_ADDR) begin
            state   <= READY;
            clrAddr <= '0;
          end else begin
            clrAddr <= clrAddr + 1'b1;
          end
        end
        READY: begin
          if (rdAcc) begin
            rdData  <= rdMerged;
            rdValid <= 1'b1;
          end
          // Requests sampled on the same edge as clr are still serviced above.
          if (clr) begin
            state   <= CLEAR;
            clrAddr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_sdp_bytewr.sv
// Testbench for ram_sdp_bytewr with default parameters. The bench drives
// random and directed traffic and compares the outputs with a word-array
// model.
module tb_ram_sdp_bytewr;
  localparam int DW = 32;
  localparam int AS = 10;
  localparam int AD = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wrEn = 1'b0;
  logic [AS-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic [3:0]    wrByteEn = '0;
  logic          rdEn = 1'b0;
  logic [AS-1:0] rdAddr = '0;
  logic [DW-1:0] rdData;
  logic          rdValid;
  logic          busy;
  logic          dropped;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] model [AD];
  logic [DW-1:0] expRd = '0;

  ram_sdp_bytewr dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrByteEn(wrByteEn),
    .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdData), .rdValid(rdValid), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; clr = 1'b0; wrEn = 1'b0; rdEn = 1'b0; wrByteEn = '0;
  endtask

  function automatic void zero_model();
    for (int i = 0; i < AD; i++) model[i] = '0;
  endfunction

  function automatic void model_write(input logic [AS-1:0] a, input logic [DW-1:0] d,
                                      input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Steps until busy is low. Gives back the number of edges taken, or -1 if
  // busy is still high after the limit.
  task automatic count_busy(output int n);
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      cyc();
      if (!busy) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    idle(); rst = 1'b1;
    cyc(); cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (rdValid !== 1'b0) begin errors++; $display("FAIL reset_rdValid: got %b want 0", rdValid); end
    checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL reset_rdData: got %h want 0", rdData); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    rst = 1'b0;
    count_busy(n);
    checks++; if (n != AD) begin errors++; $display("FAIL reset_sweep_len: got %0d want %0d", n, AD); end
    zero_model();
    expRd = '0;
  endtask

  task automatic test_read_zero();
    for (int i = 0; i < 6; i++) begin
      idle(); rdEn = 1'b1; rdAddr = AS'($urandom);
      cyc();
      checks++; if (rdValid !== 1'b1) begin errors++; $display("FAIL zero_rdValid: got %b want 1", rdValid); end
      checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL zero_rdData: addr %0d got %h want 0", rdAddr, rdData); end
      idle();
      cyc();
      checks++; if (rdValid !== 1'b0) begin errors++; $display("FAIL zero_rdValid_pulse: got %b want 0", rdValid); end
    end
  endtask

  task automatic test_bytewr();
    idle(); wrEn = 1'b1; wrAddr = 5; wrData = 32'hDEADBEEF; wrByteEn = 4'b1111;
    cyc(); model_write(5, 32'hDEADBEEF, 4'b1111);
    wrData = 32'h11223344; wrByteEn = 4'b0101;
    cyc(); model_write(5, 32'h11223344, 4'b0101);
    idle(); rdEn = 1'b1; rdAddr = 5;
    cyc();
    expRd = 32'hDE22BE44;
    checks++; if (rdData !== 32'hDE22BE44) begin errors++; $display("FAIL bytewr_merge: got %h want DE22BE44", rdData); end
    checks++; if (rdValid !== 1'b1) begin errors++; $display("FAIL bytewr_rdValid: got %b want 1", rdValid); end
  endtask

  task automatic test_collision();
    idle(); wrEn = 1'b1; wrAddr = 7; wrData = 32'h12345678; wrByteEn = 4'hF;
    cyc(); model_write(7, 32'h12345678, 4'hF);
    wrData = 32'hA5A5A5A5; wrByteEn = 4'b0011; rdEn = 1'b1; rdAddr = 7;
    cyc(); model_write(7, 32'hA5A5A5A5, 4'b0011);
    checks++; if (rdData !== 32'h1234A5A5) begin errors++; $display("FAIL collision_wrfirst: got %h want 1234A5A5", rdData); end
    // A write to a different address must not disturb a read of address 7.
    wrAddr = 9; wrData = 32'hFFFFFFFF; wrByteEn = 4'hF; rdAddr = 7;
    cyc(); model_write(9, 32'hFFFFFFFF, 4'hF);
    checks++; if (rdData !== 32'h1234A5A5) begin errors++; $display("FAIL collision_otheraddr: got %h want 1234A5A5", rdData); end
    expRd = 32'h1234A5A5;
    idle();
    cyc();
    checks++; if (rdData !== expRd) begin errors++; $display("FAIL collision_hold: got %h want %h", rdData, expRd); end
  endtask

  task automatic test_random();
    logic expV;
    for (int i = 0; i < 400; i++) begin
      idle();
      wrEn = 1'($urandom); rdEn = 1'($urandom);
      wrAddr = ($urandom_range(0, 3) == 0) ? AS'($urandom) : AS'($urandom_range(0, 15));
      rdAddr = ($urandom_range(0, 3) == 0) ? AS'($urandom) : AS'($urandom_range(0, 15));
      wrData = $urandom; wrByteEn = 4'($urandom);
      if (wrEn) model_write(wrAddr, wrData, wrByteEn);
      if (rdEn) expRd = model[rdAddr];
      expV = rdEn;
      cyc();
      checks++; if (rdValid !== expV) begin errors++; $display("FAIL rand_rdValid: cycle %0d got %b want %b", i, rdValid, expV); end
      checks++; if (rdData !== expRd) begin errors++; $display("FAIL rand_rdData: cycle %0d got %h want %h", i, rdData, expRd); end
      checks++; if (dropped !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rand_idle_flags: dropped %b busy %b want 0 0", dropped, busy); end
    end
  endtask

  task automatic test_clr_sweep();
    int n;
    logic preBusy, expDrop;
    // clr together with a write and a read: both are still serviced on this edge.
    idle(); clr = 1'b1; wrEn = 1'b1; wrAddr = 3; wrData = 32'hFFFFFFFF; wrByteEn = 4'hF;
    rdEn = 1'b1; rdAddr = 3;
    cyc();
    expRd = 32'hFFFFFFFF;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", busy); end
    checks++; if (rdValid !== 1'b1 || rdData !== expRd) begin errors++; $display("FAIL clr_edge_read: got %b/%h want 1/%h", rdValid, rdData, expRd); end
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      idle();
      preBusy = busy;
      rdEn = 1'($urandom); wrEn = 1'($urandom); clr = 1'($urandom);
      rdAddr = AS'($urandom); wrAddr = AS'($urandom); wrData = $urandom; wrByteEn = 4'hF;
      expDrop = preBusy & (rdEn | wrEn);
      cyc();
      checks++; if (dropped !== expDrop) begin errors++; $display("FAIL sweep_dropped: cycle %0d got %b want %b", i, dropped, expDrop); end
      checks++; if (rdValid !== 1'b0) begin errors++; $display("FAIL sweep_rdValid: cycle %0d got %b want 0", i, rdValid); end
      checks++; if (rdData !== expRd) begin errors++; $display("FAIL sweep_rdData_hold: got %h want %h", rdData, expRd); end
      if (!busy) begin n = i; break; end
    end
    checks++; if (n != AD) begin errors++; $display("FAIL clr_sweep_len: got %0d want %0d", n, AD); end
    zero_model();
    idle();
    cyc();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL clr_dropped_after: got %b want 0", dropped); end
    for (int i = 0; i < 8; i++) begin
      idle(); rdEn = 1'b1; rdAddr = (i == 0) ? AS'(3) : AS'($urandom);
      expRd = model[rdAddr];
      cyc();
      checks++; if (rdData !== expRd || rdValid !== 1'b1) begin errors++; $display("FAIL clr_readback: addr %0d got %h/%b want %h/1", rdAddr, rdData, rdValid, expRd); end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    // A read on a reset edge is discarded.
    idle(); wrEn = 1'b1; wrAddr = 2; wrData = 32'hCAFEF00D; wrByteEn = 4'hF;
    cyc();
    idle(); rst = 1'b1; rdEn = 1'b1; rdAddr = 2;
    cyc();
    checks++; if (rdValid !== 1'b0 || rdData !== 32'h0) begin errors++; $display("FAIL rst_read_discard: got %b/%h want 0/0", rdValid, rdData); end
    idle();
    count_busy(n);
    checks++; if (n != AD) begin errors++; $display("FAIL rst_read_sweep_len: got %0d want %0d", n, AD); end
    // Reset at cycle 300 of a sweep started by clr, then clr pulses inside the sweep.
    idle(); clr = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 299; i++) cyc();
    rst = 1'b1;
    cyc();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", busy); end
    idle();
    n = -1;
    for (int i = 1; i <= 3000; i++) begin
      clr = (i == 5 || i == 6 || i == 500 || i == 1000);
      cyc();
      if (!busy) begin n = i; break; end
    end
    idle();
    checks++; if (n != AD) begin errors++; $display("FAIL rst_mid_sweep_len: got %0d want %0d", n, AD); end
    zero_model();
    rdEn = 1'b1; rdAddr = 2;
    cyc();
    checks++; if (rdData !== model[2] || rdValid !== 1'b1) begin errors++; $display("FAIL rst_mid_readback: got %h/%b want %h/1", rdData, rdValid, model[2]); end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_bytewr();
    test_collision();
    test_random();
    test_clr_sweep();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
